// File: rtl/tft_pkg.sv
// Shared opcodes, screen limits and FSM state encodings for the TFT link scheduler.
package tft_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 480;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_GRANT  = 3'd1;
  localparam state_t ST_CASET  = 3'd2;
  localparam state_t ST_ARG_X  = 3'd3;
  localparam state_t ST_PASET  = 3'd4;
  localparam state_t ST_ARG_Y  = 3'd5;
  localparam state_t ST_RAMWR  = 3'd6;
  localparam state_t ST_STREAM = 3'd7;

endpackage

// File: rtl/window_cmd_gen.sv
// Maps the window-programming step (0..10) and latched window to the byte and dc to send.
module window_cmd_gen
  import tft_pkg::*;
#(
  parameter int COORD_W = 9
) (
  input  logic [3:0]           step,
  input  logic [4*COORD_W-1:0] win,
  output logic [7:0]           cmd_byte,
  output logic                 dc
);

  logic [COORD_W-1:0] x0, x1, y0, y1;

  assign {x0, x1, y0, y1} = win;

  function automatic logic [7:0] hi_byte(input logic [COORD_W-1:0] v);
    return 8'(v >> 8);
  endfunction

  always_comb begin
    cmd_byte = CMD_RAMWR;
    dc       = 1'b1;
    case (step)
      4'd0:    begin cmd_byte = CMD_CASET; dc = 1'b0; end
      4'd1:    cmd_byte = hi_byte(x0);
      4'd2:    cmd_byte = x0[7:0];
      4'd3:    cmd_byte = hi_byte(x1);
      4'd4:    cmd_byte = x1[7:0];
      4'd5:    begin cmd_byte = CMD_PASET; dc = 1'b0; end
      4'd6:    cmd_byte = hi_byte(y0);
      4'd7:    cmd_byte = y0[7:0];
      4'd8:    cmd_byte = hi_byte(y1);
      4'd9:    cmd_byte = y1[7:0];
      default: begin cmd_byte = CMD_RAMWR; dc = 1'b0; end
    endcase
  end

endmodule

// File: rtl/tft_scheduler.sv
// Arbitrates the single TFT byte transmitter between the init sequencer and two painters.
// state     | meaning
// IDLE      | no owner; pick next requester (client 0 first, then 1/2 round-robin)
// GRANT     | owner latched, window captured
// CASET     | send column-address command
// ARG_X     | send x0/x1 argument bytes
// PASET     | send page-address command
// ARG_Y     | send y0/y1 argument bytes
// RAMWR     | send memory-write command
// STREAM    | pass owner bytes through until cl_last
module tft_scheduler #(
  parameter int COORD_W  = 9,
  parameter int SCREEN_W = tft_pkg::SCREEN_W,
  parameter int SCREEN_H = tft_pkg::SCREEN_H
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           cl_req,
  output logic [2:0]           cl_grant,
  input  logic [23:0]          cl_data,
  input  logic                 cl_dc,
  input  logic [2:0]           cl_valid,
  input  logic [2:0]           cl_last,
  output logic [2:0]           cl_ready,
  output logic [2:0]           cl_err,
  input  logic [4*COORD_W-1:0] win1,
  input  logic [4*COORD_W-1:0] win2,
  output logic [7:0]           tx_data,
  output logic                 tx_dc,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 init_seen
);
  import tft_pkg::*;

  localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(SCREEN_H);

  state_t               state, cmd_next;
  logic [1:0]           owner, pick;
  logic [3:0]           step;
  logic [4*COORD_W-1:0] win_q, pick_win;
  logic                 rr_two;
  logic                 pick_valid, pick_ok;
  logic                 own_valid, own_last;
  logic [7:0]           own_data, gen_byte;
  logic                 gen_dc, in_cmd, issue;

  function automatic logic win_ok(input logic [4*COORD_W-1:0] w);
    logic [COORD_W-1:0] a, b, c, d;
    {a, b, c, d} = w;
    return (a <= b) && ({1'b0, b} < X_LIM) && (c <= d) && ({1'b0, d} < Y_LIM);
  endfunction

  // rr_two=1 favours client 2 when both painters request together
  always_comb begin
    pick_valid = 1'b0;
    pick       = 2'd0;
    if (cl_req[0]) begin
      pick_valid = 1'b1;
    end else if (init_seen) begin
      if (cl_req[1] && (!cl_req[2] || !rr_two)) begin
        pick_valid = 1'b1;
        pick       = 2'd1;
      end else if (cl_req[2]) begin
        pick_valid = 1'b1;
        pick       = 2'd2;
      end
    end
  end

  assign pick_win = (pick == 2'd2) ? win2 : win1;
  assign pick_ok  = (pick == 2'd0) || win_ok(pick_win);

  always_comb begin
    own_valid = cl_valid[0];
    own_last  = cl_last[0];
    own_data  = cl_data[7:0];
    case (owner)
      2'd1: begin own_valid = cl_valid[1]; own_last = cl_last[1]; own_data = cl_data[15:8]; end
      2'd2: begin own_valid = cl_valid[2]; own_last = cl_last[2]; own_data = cl_data[23:16]; end
      default: ;
    endcase
  end

  always_comb begin
    cmd_next = state;
    case (step)
      4'd0:    cmd_next = ST_ARG_X;
      4'd4:    cmd_next = ST_PASET;
      4'd5:    cmd_next = ST_ARG_Y;
      4'd9:    cmd_next = ST_RAMWR;
      4'd10:   cmd_next = ST_STREAM;
      default: ;
    endcase
  end

  assign in_cmd = (state == ST_CASET) || (state == ST_ARG_X) || (state == ST_PASET) ||
                  (state == ST_ARG_Y) || (state == ST_RAMWR);
  // tx_start gate tolerates a transmitter whose busy flag rises one cycle late
  assign issue  = !tx_busy && !tx_start && (in_cmd || ((state == ST_STREAM) && own_valid));

  window_cmd_gen #(.COORD_W(COORD_W)) u_cmd_gen (
    .step     (step),
    .win      (win_q),
    .cmd_byte (gen_byte),
    .dc       (gen_dc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= 2'd0;
      step      <= 4'd0;
      win_q     <= '0;
      rr_two    <= 1'b0;
      init_seen <= 1'b0;
      cl_grant  <= 3'b000;
      cl_ready  <= 3'b000;
      cl_err    <= 3'b000;
      tx_data   <= 8'h00;
      tx_dc     <= 1'b0;
      tx_start  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      cl_ready <= 3'b000;
      cl_err   <= 3'b000;
      case (state)
        ST_IDLE: begin
          cl_grant <= 3'b000;
          if (pick_valid) begin
            if (pick_ok) begin
              owner    <= pick;
              cl_grant <= 3'b001 << pick;
              win_q    <= pick_win;
              step     <= 4'd0;
              state    <= ST_GRANT;
            end else begin
              cl_err <= 3'b001 << pick;
              rr_two <= (pick == 2'd1);
            end
          end
        end
        ST_GRANT: state <= (owner == 2'd0) ? ST_STREAM : ST_CASET;
        ST_STREAM: begin
          if (issue) begin
            tx_start <= 1'b1;
            tx_data  <= own_data;
            tx_dc    <= (owner == 2'd0) ? cl_dc : 1'b1;
            cl_ready <= cl_grant;
            if (own_last) begin
              state <= ST_IDLE;
              if (owner == 2'd0) init_seen <= 1'b1;
              else               rr_two    <= ~rr_two;
            end
          end
        end
        default: begin
          if (issue) begin
            tx_start <= 1'b1;
            tx_data  <= gen_byte;
            tx_dc    <= gen_dc;
            step     <= step + 4'd1;
            state    <= cmd_next;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tft_scheduler.sv
// Scoreboard bench: stimulus queues expected transmitter bytes, a negedge monitor pops and compares.
module tb_tft_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  cl_grant, cl_ready, cl_err;
  logic [7:0]  tx_data;
  logic        tx_dc, tx_start, init_seen;
  logic        tx_busy = 1'b0;
  logic        dc0 = 1'b0;
  logic        req [3];
  logic        val [3];
  logic        lst [3];
  logic [7:0]  dat [3];
  logic [35:0] w1, w2;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [2:0] g;
    logic [7:0] d;
    logic       dc;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic prev_start = 1'b0;

  localparam logic [35:0] W_FULL  = {9'd0, 9'd319, 9'd0, 9'd479};
  localparam logic [35:0] W_TILE  = {9'd16, 9'd31, 9'd100, 9'd131};
  localparam logic [35:0] W_BADX  = {9'd10, 9'd5, 9'd0, 9'd0};
  localparam logic [35:0] W_EDGEX = {9'd0, 9'd320, 9'd0, 9'd10};
  localparam logic [35:0] W_EDGEY = {9'd0, 9'd10, 9'd0, 9'd480};

  logic [7:0] full_bytes [11] = '{8'h2A, 8'h00, 8'h00, 8'h01, 8'h3F, 8'h2B,
                                  8'h00, 8'h00, 8'h01, 8'hDF, 8'h2C};
  logic       full_dc    [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  tft_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cl_req    ({req[2], req[1], req[0]}),
    .cl_grant  (cl_grant),
    .cl_data   ({dat[2], dat[1], dat[0]}),
    .cl_dc     (dc0),
    .cl_valid  ({val[2], val[1], val[0]}),
    .cl_last   ({lst[2], lst[1], lst[0]}),
    .cl_ready  (cl_ready),
    .cl_err    (cl_err),
    .win1      (w1),
    .win2      (w2),
    .tx_data   (tx_data),
    .tx_dc     (tx_dc),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .init_seen (init_seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [2:0] g, input logic [7:0] d, input logic dc,
                               input logic rdy);
    exp_t e;
    e.g = g; e.d = d; e.dc = dc; e.rdy = rdy;
    q.push_back(e);
  endfunction

  task automatic exp_window(input logic [2:0] g, input logic [35:0] w);
    logic [8:0] x0, x1, y0, y1;
    {x0, x1, y0, y1} = w;
    push(g, 8'h2A, 1'b0, 1'b0);
    push(g, {7'b0, x0[8]}, 1'b1, 1'b0); push(g, x0[7:0], 1'b1, 1'b0);
    push(g, {7'b0, x1[8]}, 1'b1, 1'b0); push(g, x1[7:0], 1'b1, 1'b0);
    push(g, 8'h2B, 1'b0, 1'b0);
    push(g, {7'b0, y0[8]}, 1'b1, 1'b0); push(g, y0[7:0], 1'b1, 1'b0);
    push(g, {7'b0, y1[8]}, 1'b1, 1'b0); push(g, y1[7:0], 1'b1, 1'b0);
    push(g, 8'h2C, 1'b0, 1'b0);
  endtask

  task automatic exp_pixels(input logic [2:0] g, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++)
      push(g, base + 8'(i), (g == 3'b001) ? (i != 0) : 1'b1, 1'b1);
  endtask

  task automatic client_txn(input int c, input int n, input logic [7:0] base, output int wait_cyc);
    int k;
    req[c] = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!cl_grant[c] && k < 2000);
    wait_cyc = k;
    if (!cl_grant[c]) begin
      total++; bad++;
      $display("FAIL grant_timeout: client %0d got no grant in %0d cycles", c, k);
      req[c] = 1'b0;
      return;
    end
    req[c] = 1'b0;
    for (int i = 0; i < n; i++) begin
      dat[c] = base + 8'(i);
      val[c] = 1'b1;
      lst[c] = (i == n - 1);
      if (c == 0) dc0 = (i != 0);
      k = 0;
      do begin @(negedge clk); k++; end while (!cl_ready[c] && k < 200);
      if (!cl_ready[c]) begin
        total++; bad++;
        $display("FAIL ready_timeout: client %0d byte %0d not consumed", c, i);
        break;
      end
    end
    val[c] = 1'b0;
    lst[c] = 1'b0;
  endtask

  task automatic client_err(input int c, input string nm);
    int k;
    req[c] = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!cl_err[c] && k < 200);
    check(nm, 32'({cl_err, cl_grant[c]}), 32'({3'b001 << c, 1'b0}));
    req[c] = 1'b0;
    @(negedge clk);
    check({nm, "_width"}, 32'(cl_err), 32'd0);
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((q.size() != 0 || cl_grant != 3'b000) && k < 500) begin @(negedge clk); k++; end
    check(nm, 32'(q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        check("start_gap", 32'(prev_start), 32'd0);
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_byte: got data=%0h dc=%0b grant=%0b want no byte",
                   tx_data, tx_dc, cl_grant);
        end else begin
          mon_e = q.pop_front();
          check("tx_byte", 32'({cl_grant, tx_data, tx_dc, cl_ready}),
                32'({mon_e.g, mon_e.d, mon_e.dc, (mon_e.rdy ? mon_e.g : 3'b000)}));
        end
      end else begin
        check("ready_idle", 32'(cl_ready), 32'd0);
      end
    end
    prev_start <= tx_start & rst_n;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    int wa, wb, cnt, k;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; val[i] = 1'b0; lst[i] = 1'b0; dat[i] = 8'h00;
    end
    w1 = W_FULL;
    w2 = W_TILE;
    #1 rst_n = 1'b0;
    #11;
    check("rst_grant", 32'(cl_grant), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_dc", 32'(tx_dc), 32'd0);
    check("rst_ready", 32'(cl_ready), 32'd0);
    check("rst_err", 32'(cl_err), 32'd0);
    check("rst_init", 32'(init_seen), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // client 0 beats client 1, then client 1 gets the full-screen window
    push(3'b001, 8'h11, 1'b0, 1'b1); push(3'b001, 8'h12, 1'b1, 1'b1); push(3'b001, 8'h13, 1'b1, 1'b1);
    for (int i = 0; i < 11; i++) push(3'b010, full_bytes[i], full_dc[i], 1'b0);
    exp_pixels(3'b010, 4, 8'hA0);
    @(negedge clk);
    fork
      client_txn(0, 3, 8'h11, wa);
      client_txn(1, 4, 8'hA0, wb);
    join
    check("grant_latency", 32'(wa), 32'd1);
    check("init_seen", 32'(init_seen), 32'd1);
    drain("drain_t1");

    // pointer now favours client 2 after client 1 completed
    exp_window(3'b100, W_TILE); exp_pixels(3'b100, 2, 8'hC0);
    exp_window(3'b010, W_FULL); exp_pixels(3'b010, 2, 8'hB0);
    exp_window(3'b100, W_TILE); exp_pixels(3'b100, 2, 8'hC2);
    exp_window(3'b010, W_FULL); exp_pixels(3'b010, 2, 8'hB2);
    fork
      begin client_txn(1, 2, 8'hB0, wa); client_txn(1, 2, 8'hB2, wa); end
      begin client_txn(2, 2, 8'hC0, wb); client_txn(2, 2, 8'hC2, wb); end
    join
    drain("drain_t2");

    // client 2 window rejected, client 1 served next
    w2 = W_BADX;
    exp_window(3'b010, W_FULL); exp_pixels(3'b010, 2, 8'hD0);
    fork
      client_err(2, "err_x0_gt_x1");
      client_txn(1, 2, 8'hD0, wa);
    join
    drain("drain_t3");
    w2 = W_EDGEX;
    client_err(2, "err_x1_320");
    w2 = W_EDGEY;
    client_err(2, "err_y1_480");
    w2 = W_TILE;

    // transmitter busy for 20 cycles mid-stream
    exp_pixels(3'b001, 5, 8'hE0);
    fork
      client_txn(0, 5, 8'hE0, wa);
      begin
        k = 0;
        do begin @(negedge clk); k++; end while (!cl_ready[0] && k < 200);
        tx_busy = 1'b1;
        cnt = 0;
        repeat (20) begin
          @(negedge clk);
          if (tx_start || cl_ready != 3'b000) cnt++;
        end
        check("busy_hold", 32'(cnt), 32'd0);
        tx_busy = 1'b0;
        cnt = 0;
        repeat (2) begin
          @(negedge clk);
          if (tx_start) cnt++;
        end
        check("busy_release", 32'(cnt), 32'd1);
      end
    join
    drain("drain_t4");

    // reset in the middle of the y arguments
    for (int i = 0; i < 7; i++) push(3'b010, full_bytes[i], full_dc[i], 1'b0);
    req[1] = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!cl_grant[1] && k < 50);
    req[1] = 1'b0;
    cnt = 0;
    k = 0;
    while (cnt < 7 && k < 100) begin
      @(negedge clk);
      k++;
      if (tx_start) cnt++;
    end
    check("reach_arg_y", 32'(cnt), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("abort_grant", 32'(cl_grant), 32'd0);
    check("abort_start", 32'(tx_start), 32'd0);
    check("abort_data", 32'({tx_data, tx_dc}), 32'd0);
    check("abort_ready_err", 32'({cl_ready, cl_err}), 32'd0);
    check("abort_init", 32'(init_seen), 32'd0);
    check("abort_queue", 32'(q.size()), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // client 1 must wait for a fresh client 0 transaction
    push(3'b001, 8'h55, 1'b0, 1'b1); push(3'b001, 8'h56, 1'b1, 1'b1);
    exp_window(3'b010, W_FULL); exp_pixels(3'b010, 2, 8'hF0);
    fork
      client_txn(1, 2, 8'hF0, wb);
      begin
        cnt = 0;
        repeat (10) begin
          @(negedge clk);
          if (cl_grant != 3'b000) cnt++;
        end
        check("held_off", 32'(cnt), 32'd0);
        client_txn(0, 2, 8'h55, wa);
      end
    join
    check("held_wait", 32'(wb > 10), 32'd1);
    drain("drain_t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
